uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port uart_byte_ready  output  1  one-cycle pulse when a valid byte is complete.
REQ-006 SHALL have port uart_byte  output  8  last valid received byte.
REQ-007 SHALL have port framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port rx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; the FSM sees only the synchronized rx_s, and the synchronizer resets to 1.
REQ-010 SHALL implement the FSM states IDLE, START, DATA, STOP, BREAK, encoded in 3 bits.
REQ-011 IDLE SHALL go to START on the first cycle rx_s is 0, and clear the bit timer to 0.
REQ-012 START SHALL sample rx_s when the timer reaches CLKS_PER_BIT/2-1 (integer division).
- If rx_s = 0: go to DATA, clear the timer and the bit index.
- If rx_s = 1: go back to IDLE as a false start, with no output pulse.
REQ-013 DATA SHALL sample rx_s when the timer reaches CLKS_PER_BIT-1, shift it into bit[index] (LSB first), clear the timer and increment the 3-bit index.
- After index 7 is sampled, go to STOP.
REQ-014 STOP SHALL sample rx_s when the timer reaches CLKS_PER_BIT-1.
- If rx_s = 1: load uart_byte from the shift register, pulse uart_byte_ready on the next cycle, go to IDLE.
- If rx_s = 0: pulse framing_error on the next cycle, leave uart_byte unchanged, go to BREAK.
REQ-015 BREAK SHALL stay until rx_s = 1, then go to IDLE; no pulses are issued while in BREAK.
REQ-016 The bit timer SHALL be 16 bits wide and SHALL never exceed CLKS_PER_BIT-1.
REQ-017 uart_byte_ready and framing_error SHALL each be high for exactly one clk cycle per event, and SHALL never be high together.
REQ-018 uart_byte SHALL hold its value from a ready pulse until the next ready pulse, so a downstream consumer may read it any number of cycles later.
REQ-019 A start edge that arrives in the same cycle STOP returns to IDLE SHALL be detected on the following IDLE cycle without loss; back-to-back frames SHALL be received.
REQ-020 Latency SHALL be: the uart_byte_ready rising edge occurs 2 (synchronizer) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk cycles after the rx falling edge of the start bit, ±1 cycle.
REQ-021 rx_busy SHALL be combinationally (state != IDLE).

Reset
REQ-022 While rst = 1, the following SHALL hold:
- state = IDLE; timer, index and shift register = 0;
- uart_byte = 8'h00; uart_byte_ready = 0; framing_error = 0; rx_busy = 0.
REQ-023 rst asserted mid-frame SHALL abort the frame immediately with no pulse; after release, the receiver SHALL wait for a fresh falling edge in IDLE.
REQ-024 Reset release SHALL take effect on the first posedge clk with rst = 0; a line held low at release SHALL be treated as a start bit.

Verification (CLKS_PER_BIT = 8)
REQ-025 Send frame 0xA5 with a good stop bit -> exactly one uart_byte_ready pulse, uart_byte = 8'hA5, framing_error stays 0, and the ready pulse falls within REQ-020 latency.
REQ-026 Send 0x00, 0xFF, 0x5A back-to-back with no idle gap -> three ready pulses with uart_byte = 00, FF, 5A in order.
REQ-027 Drive a 3-cycle low glitch on idle rx -> no pulse, uart_byte unchanged, FSM back in IDLE within 8 cycles.
REQ-028 Send 0x3C, then a frame 0x81 with stop bit 0 and rx held low 20 cycles before returning high -> one framing_error pulse, no ready pulse for 0x81, uart_byte still 8'h3C, then a following 0x42 frame is received correctly.
REQ-029 Assert rst during data bit 4 of a frame -> all outputs 0 immediately (asynchronously), no pulse; the next full frame 0x7E is received correctly.
REQ-030 Send 0x96 while checking rx_busy -> rx_busy is high from the first FSM START cycle through the STOP sample, then low.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer.
// It samples mid-bit using a programmable bit timer, and reports either
// a received byte or a framing error (stop bit low) as single-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       uart_byte_ready,
  output logic [7:0] uart_byte,
  output logic       framing_error,
  output logic       rx_busy
);

  // Timer compare points.
  // The start bit is checked half a bit in. Data and stop bits are then
  // sampled a full bit period apart, which lands each sample mid-bit.
  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_rx_meta, r_rx_s;
  logic [15:0] r_timer, w_timer_next;
  logic [2:0]  r_index, w_index_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [7:0]  r_byte, w_byte_next;
  logic        r_ready, w_ready_next;
  logic        r_ferr, w_ferr_next;

  // Two-flop synchronizer for the asynchronous line.
  // It resets to the idle (high) level so that a reset cannot fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State and datapath registers. Pulses are registered, so each pulse
  // appears on the cycle after its stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_index <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_index <= w_index_next;
      r_shift <= w_shift_next;
      r_byte  <= w_byte_next;
      r_ready <= w_ready_next;
      r_ferr  <= w_ferr_next;
    end
  end

  // Next-state, bit timing and sampling decisions.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_index_next = r_index;
    w_shift_next = r_shift;
    w_byte_next  = r_byte;
    w_ready_next = 1'b0;
    w_ferr_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_next = '0;
        if (!r_rx_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (r_timer == LP_HALF) begin
          w_timer_next = '0;
          if (!r_rx_s) begin
            w_state_next = ST_DATA;
            w_index_next = '0;
          end else begin
            // Line went back high before mid start bit: treat it as noise.
            w_state_next = ST_IDLE;
          end
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      ST_DATA: begin
        if (r_timer == LP_FULL) begin
          w_timer_next          = '0;
          w_shift_next[r_index] = r_rx_s;
          w_index_next          = r_index + 3'd1;
          if (r_index == 3'd7) begin
            w_state_next = ST_STOP;
          end
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      ST_STOP: begin
        if (r_timer == LP_FULL) begin
          w_timer_next = '0;
          if (r_rx_s) begin
            w_byte_next  = r_shift;
            w_ready_next = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            // The last good byte is kept intact on a framing error.
            w_ferr_next  = 1'b1;
            w_state_next = ST_BREAK;
          end
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      ST_BREAK: begin
        w_timer_next = '0;
        if (r_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  assign uart_byte_ready = r_ready;
  assign uart_byte       = r_byte;
  assign framing_error   = r_ferr;
  assign rx_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx with 8 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       uart_byte_ready;
  logic [7:0] uart_byte;
  logic       framing_error;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int last_ready_cyc = 0;
  logic prev_ready = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .uart_byte_ready (uart_byte_ready),
    .uart_byte       (uart_byte),
    .framing_error   (framing_error),
    .rx_busy         (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (uart_byte_ready) begin
      ready_cnt++;
      last_ready_cyc = cyc;
      got_q.push_back(uart_byte);
      $display("t=%0t ready byte=%02h", $time, uart_byte);
    end
    if (framing_error) begin
      ferr_cnt++;
      $display("t=%0t framing_error pulse", $time);
    end
    if (uart_byte_ready && framing_error) both_cnt++;
    if ((uart_byte_ready && prev_ready) || (framing_error && prev_ferr)) wide_cnt++;
    prev_ready = uart_byte_ready;
    prev_ferr  = framing_error;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Callers start aligned at one time unit after a rising edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fall_cyc;
  int lat;
  int low_cnt;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(uart_byte_ready), 32'd0);
    chk("rst_byte", 32'(uart_byte), 32'h00);
    chk("rst_ferr", 32'(framing_error), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(4);

    // Single good frame and its latency.
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    idle(8);
    lat = last_ready_cyc - fall_cyc;
    chk("a5_cnt", 32'(ready_cnt), 32'd1);
    chk("a5_byte", 32'(uart_byte), 32'hA5);
    chk("a5_ferr", 32'(ferr_cnt), 32'd0);
    chk("a5_latency", 32'((lat >= 78) && (lat <= 80)), 32'd1);
    $display("frame A5 latency=%0d cycles", lat);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle(8);
    chk("b2b_cnt", 32'(ready_cnt), 32'd4);
    chk("b2b_b0", 32'(got_q[1]), 32'h00);
    chk("b2b_b1", 32'(got_q[2]), 32'hFF);
    chk("b2b_b2", 32'(got_q[3]), 32'h5A);

    // Three-cycle low glitch: false start.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    chk("glitch_busy_start", 32'(rx_busy), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_busy_idle", 32'(rx_busy), 32'd0);
    chk("glitch_cnt", 32'(ready_cnt), 32'd4);
    chk("glitch_byte", 32'(uart_byte), 32'h5A);
    $display("glitch done busy=%0b", rx_busy);

    // Good frame, then a bad stop bit followed by a held-low break.
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("brk_busy", 32'(rx_busy), 32'd1);
    idle(16);
    chk("brk_ferr", 32'(ferr_cnt), 32'd1);
    chk("brk_cnt", 32'(ready_cnt), 32'd5);
    chk("brk_byte", 32'(uart_byte), 32'h3C);
    chk("brk_busy_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h42, 1'b1);
    idle(8);
    chk("after_brk_cnt", 32'(ready_cnt), 32'd6);
    chk("after_brk_byte", 32'(uart_byte), 32'h42);

    // Reset in the middle of data bit 4.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(rx_busy), 32'd0);
    chk("mid_rst_byte", 32'(uart_byte), 32'h00);
    chk("mid_rst_ready", 32'(uart_byte_ready), 32'd0);
    chk("mid_rst_ferr", 32'(framing_error), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(90);
    chk("post_rst_cnt", 32'(ready_cnt), 32'd6);
    chk("post_rst_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h7E, 1'b1);
    idle(8);
    chk("post_rst_byte", 32'(uart_byte), 32'h7E);
    chk("post_rst_cnt2", 32'(ready_cnt), 32'd7);

    // rx_busy window over frame 0x96.
    low_cnt = 0;
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #2;
        chk("busy_pre_start", 32'(rx_busy), 32'd0);
        for (int i = 0; i < 76; i++) begin
          @(posedge clk);
          #2;
          if (!rx_busy) low_cnt++;
        end
        @(posedge clk);
        #2;
        chk("busy_after_stop", 32'(rx_busy), 32'd0);
      end
    join
    idle(8);
    chk("busy_window_lows", 32'(low_cnt), 32'd0);
    chk("busy_byte", 32'(uart_byte), 32'h96);
    chk("busy_cnt", 32'(ready_cnt), 32'd8);

    // Pulse shape over the whole run.
    chk("pulse_overlap", 32'(both_cnt), 32'd0);
    chk("pulse_width", 32'(wide_cnt), 32'd0);
    chk("ferr_total", 32'(ferr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
